fp_addsub_arbiter: RTL and testbench
====================================

Name: fp_addsub_arbiter

Overview:
- Shares the single floating-point add/subtract unit among NREQ requesters: the LN CORDIC controller, the exp/scaling controller and future sequencers.
- Round-robin arbitration; registers the winner's operands and operation, then pulses Begin_SUM.
- Waits for ACK_ADD_SUBT, returns the result with a one-cycle acknowledge to the winner.
- Sits between the requester FSMs and the FP adder; also guards against a hung adder with a timeout.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 32, operand/result width (IEEE-754 single).
- TIMEOUT, 255, max WAIT cycles before abort (1..65535).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ  in  NREQ  per-requester request level.
- REQ_ADD_SUBT  in  NREQ  per-requester op: 0 add, 1 subtract.
- REQ_A  in  NREQ*W  operand A, requester k at bits [k*W +: W].
- REQ_B  in  NREQ*W  operand B, same packing.
- ACK_REQ  out  NREQ  one-hot, one-cycle done pulse to the served requester.
- RESULT  out  W  result register, valid while ACK_REQ pulses; held otherwise.
- BUSY  out  1  high in every state except IDLE.
- ERR_TIMEOUT  out  1  sticky; set on abort, cleared only by reset.
- Begin_SUM  out  1  one-cycle start pulse to the FP adder.
- ADD_SUBT  out  1  registered op to the adder.
- OP_A, OP_B  out  W  registered operands to the adder.
- ACK_ADD_SUBT  in  1  adder done (level or pulse).
- RES_ADD_SUBT  in  W  adder result, valid with ACK_ADD_SUBT.

Behaviour:
- Reset (RST_N low, async): state IDLE; all outputs 0; round-robin pointer 0; timeout counter 0.
- FSM states and transitions:
  - IDLE: if any REQ bit is set, pick the first set bit searching from pointer upward with wrap; latch grant index g; go to LOAD. Otherwise stay.
  - LOAD: register ADD_SUBT, OP_A and OP_B from requester g; clear the counter; go to START. The grant is committed from here; a withdrawn REQ is ignored.
  - START: Begin_SUM=1 for exactly one cycle; go to WAIT. ACK_ADD_SUBT is ignored in this cycle.
  - WAIT: if ACK_ADD_SUBT, capture RES_ADD_SUBT into RESULT and go to DONE. Else increment the counter. When the counter reaches TIMEOUT-1 without ack, set RESULT=0, set ERR_TIMEOUT and go to DONE.
  - DONE: ACK_REQ[g]=1 for one cycle; pointer=(g+1) mod NREQ; go to IDLE.
- Latency: REQ seen in IDLE at cycle 0 -> Begin_SUM at cycle 2 -> adder ack at cycle 2+L -> ACK_REQ at cycle 3+L.
- Back-to-back throughput: one operation per L+4 cycles.
- Requester rule: REQ drops on the clock edge that samples ACK_REQ high. The following IDLE cycle therefore never re-serves the same request.
- Fairness: a requester holding REQ is served within NREQ grants.
- OP_A, OP_B and ADD_SUBT stay stable from LOAD through DONE. The adder sees constant inputs for the whole operation.
- If ACK_ADD_SUBT and the timeout limit occur in the same WAIT cycle, the ack wins and no error is flagged.
- Reset mid-operation: immediate return to IDLE, no ACK_REQ. The adder is reset by the same net at system level.
- Simultaneous requests: only one is granted per arbitration; the others wait, with no loss.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD, START, WAIT, DONE, 3-bit), default W and NREQ, and the op encoding (ADD=0, SUB=1).
- One sub-module: rr_pick. It is combinational: inputs REQ vector and pointer; outputs a found flag and the grant index. Reused by the other arbiters in the project.

Test Plan:
- Single add: REQ=0001, A=0x3F800000, B=0x40000000, op 0; model adder L=5. Expect Begin_SUM at cycle 2, ACK_REQ=0001 at cycle 8, RESULT=0x40400000.
- Subtract on requester 2: A=0x40400000, B=0x3F800000, op 1. Expect ADD_SUBT=1 stable LOAD..DONE, ACK_REQ=0100, RESULT=0x40000000.
- Fairness: REQ=1111 held continuously, each requester drops REQ after its ack. Expect grant order 0,1,2,3, exactly four Begin_SUM pulses, no double service.
- Pointer wrap: after serving requester 3, assert REQ=1001. Expect grant 0 then 3.
- Timeout: TIMEOUT=16, adder never acks. Expect ACK_REQ pulse 16 cycles after WAIT entry, RESULT=0, ERR_TIMEOUT stays 1 until RST_N low. Repeat with the ack arriving on cycle 16 exactly: RESULT valid, ERR_TIMEOUT=0.
- Reset mid-WAIT: RST_N low for 1 cycle during WAIT. Expect all outputs 0 asynchronously, state IDLE, pointer 0, no ACK_REQ. A subsequent request completes normally.

Source files
------------

// File: rtl/fp_addsub_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_addsub_arbiter_pkg                                                |
// | Shared state encoding, defaults and op codes for the FP add arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fp_addsub_arbiter_pkg;

  localparam int unsigned C_DEF_W    = 32;
  localparam int unsigned C_DEF_NREQ = 4;

  localparam logic C_OP_ADD = 1'b0;
  localparam logic C_OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_addsub_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_addsub_arbiter_rr_pick                                            |
// | Combinational round-robin pick: first set request at/after pointer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp_addsub_arbiter_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_found,
  output logic [IW-1:0]   o_grant
);

  localparam logic [IW:0] C_NREQ = (IW+1)'(NREQ);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IW-1:0]     w_off;
  logic [IW:0]       w_sum;

  // Rotate so the pointer position lands at bit 0, then pick the lowest set bit.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = IW'(i);
        o_found = 1'b1;
      end
    end
  end

  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_grant = (w_sum >= C_NREQ) ? IW'(w_sum - C_NREQ) : w_sum[IW-1:0];

endmodule
`default_nettype wire

// File: rtl/fp_addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_addsub_arbiter                                                    |
// | Round-robin sharing of one FP add/sub unit, with hung-adder timeout. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp_addsub_arbiter
  import fp_addsub_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = C_DEF_NREQ,
  parameter int unsigned W       = C_DEF_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ-1:0]   REQ_ADD_SUBT,
  input  logic [NREQ*W-1:0] REQ_A,
  input  logic [NREQ*W-1:0] REQ_B,
  output logic [NREQ-1:0]   ACK_REQ,
  output logic [W-1:0]      RESULT,
  output logic              BUSY,
  output logic              ERR_TIMEOUT,
  output logic              Begin_SUM,
  output logic              ADD_SUBT,
  output logic [W-1:0]      OP_A,
  output logic [W-1:0]      OP_B,
  input  logic              ACK_ADD_SUBT,
  input  logic [W-1:0]      RES_ADD_SUBT
);

  localparam int unsigned IW        = $clog2(NREQ);
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT - 1);

  state_t          r_state;
  state_t          w_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   w_pick;
  logic            w_found;
  logic [15:0]     r_cnt;
  logic            w_to_hit;
  logic            r_add_subt;
  logic [W-1:0]    r_op_a;
  logic [W-1:0]    r_op_b;
  logic [W-1:0]    r_result;
  logic            r_err;
  logic [W-1:0]    w_a [NREQ];
  logic [W-1:0]    w_b [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign w_a[k] = REQ_A[k*W +: W];
    assign w_b[k] = REQ_B[k*W +: W];
  end

  fp_addsub_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_grant (w_pick)
  );

  assign w_to_hit = (r_cnt == C_TO_LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  if (ACK_ADD_SUBT || w_to_hit) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_add_subt <= C_OP_ADD;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_found) r_grant <= w_pick;
        ST_LOAD: begin
          r_add_subt <= REQ_ADD_SUBT[r_grant];
          r_op_a     <= w_a[r_grant];
          r_op_b     <= w_b[r_grant];
          r_cnt      <= '0;
        end
        // An ack in the limit cycle still wins over the abort.
        ST_WAIT: begin
          if (ACK_ADD_SUBT) begin
            r_result <= RES_ADD_SUBT;
          end else if (w_to_hit) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: r_ptr <= (r_grant == IW'(NREQ - 1)) ? '0 : r_grant + IW'(1);
        default: ;
      endcase
    end
  end

  assign ACK_REQ     = (r_state == ST_DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << r_grant) : '0;
  assign Begin_SUM   = (r_state == ST_START);
  assign BUSY        = (r_state != ST_IDLE);
  assign RESULT      = r_result;
  assign ERR_TIMEOUT = r_err;
  assign ADD_SUBT    = r_add_subt;
  assign OP_A        = r_op_a;
  assign OP_B        = r_op_b;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_addsub_arbiter                                                 |
// | Scoreboard bench with a latency-programmable adder model.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fp_addsub_arbiter;
  import fp_addsub_arbiter_pkg::*;

  localparam int NREQ    = 4;
  localparam int W       = 32;
  localparam int TIMEOUT = 16;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [NREQ-1:0]   REQ;
  logic [NREQ-1:0]   REQ_ADD_SUBT;
  logic [NREQ*W-1:0] REQ_A;
  logic [NREQ*W-1:0] REQ_B;
  logic [NREQ-1:0]   ACK_REQ;
  logic [W-1:0]      RESULT;
  logic              BUSY;
  logic              ERR_TIMEOUT;
  logic              Begin_SUM;
  logic              ADD_SUBT;
  logic [W-1:0]      OP_A;
  logic [W-1:0]      OP_B;
  logic              ACK_ADD_SUBT;
  logic [W-1:0]      RES_ADD_SUBT;

  fp_addsub_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_ADD_SUBT(REQ_ADD_SUBT),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .ACK_REQ(ACK_REQ), .RESULT(RESULT),
    .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT), .Begin_SUM(Begin_SUM),
    .ADD_SUBT(ADD_SUBT), .OP_A(OP_A), .OP_B(OP_B),
    .ACK_ADD_SUBT(ACK_ADD_SUBT), .RES_ADD_SUBT(RES_ADD_SUBT)
  );

  typedef struct { int idx; logic [W-1:0] res; } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;
  int bs_cnt = 0;
  int bs_cyc = -1;
  int adder_lat = 5;
  bit adder_hang = 1'b0;

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end
  initial forever begin
    @(negedge CLK);
    if (Begin_SUM === 1'b1) begin bs_cnt++; bs_cyc = cyc; end
  end

  // Known IEEE values for the directed cases, integer arithmetic as a stand-in otherwise.
  function automatic logic [W-1:0] fp_ref(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && op == C_OP_ADD) return 32'h40400000;
    if (a == 32'h40400000 && b == 32'h3F800000 && op == C_OP_SUB) return 32'h40000000;
    return op ? (a - b) : (a + b);
  endfunction

  initial begin
    logic [W-1:0] a_s, b_s;
    logic         op_s;
    ACK_ADD_SUBT = 1'b0;
    RES_ADD_SUBT = '0;
    forever begin
      @(posedge CLK); #1;
      if (Begin_SUM === 1'b1 && !adder_hang) begin
        a_s = OP_A; b_s = OP_B; op_s = ADD_SUBT;
        repeat (adder_lat) @(posedge CLK);
        #1;
        ACK_ADD_SUBT = 1'b1;
        RES_ADD_SUBT = fp_ref(a_s, b_s, op_s);
        @(posedge CLK); #1;
        ACK_ADD_SUBT = 1'b0;
      end
    end
  end

  task automatic drive_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    REQ_A[k*W +: W] = a;
    REQ_B[k*W +: W] = b;
    REQ_ADD_SUBT[k] = op;
    REQ[k]          = 1'b1;
  endtask

  // Waits for ACK_REQ; the served requester drops REQ on the edge that samples it.
  task automatic wait_ack(output bit ok, output int idx, output int at);
    ok = 1'b0; idx = -1; at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (ACK_REQ !== '0) begin
        ok = 1'b1; at = cyc;
        for (int k = 0; k < NREQ; k++) if (ACK_REQ[k] === 1'b1) idx = k;
        if (idx >= 0) REQ[idx] = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; REQ = '0; REQ_ADD_SUBT = '0; REQ_A = '0; REQ_B = '0;
    repeat (3) @(negedge CLK);
    n_cmp++;
    if ({ACK_REQ, RESULT, BUSY, ERR_TIMEOUT, Begin_SUM, ADD_SUBT, OP_A, OP_B} !== '0) begin
      n_mis++; $display("FAIL reset_outputs: got %h expected 0", {ACK_REQ, RESULT, BUSY, ERR_TIMEOUT, Begin_SUM, ADD_SUBT, OP_A, OP_B});
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({BUSY, ACK_REQ} !== '0) begin
      n_mis++; $display("FAIL reset_idle: got %h expected 0", {BUSY, ACK_REQ});
    end
  endtask

  task automatic test_fairness();
    bit ok; int idx, at, prev, bs0;
    exp_t e;
    repeat (2) @(negedge CLK);
    bs0 = bs_cnt; prev = -1;
    for (int k = 0; k < NREQ; k++) begin
      drive_req(k, 32'h1000 * (k + 1), 32'(k + 7), k[0]);
      sb.push_back('{k, fp_ref(32'h1000 * (k + 1), 32'(k + 7), k[0])});
    end
    for (int j = 0; j < NREQ; j++) begin
      wait_ack(ok, idx, at);
      n_cmp++;
      if (!ok || sb.size() == 0) begin
        n_mis++; $display("FAIL fair_ack_timeout: got no ack expected ack %0d", j);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (idx != e.idx) begin n_mis++; $display("FAIL fair_grant: got %0d expected %0d", idx, e.idx); end
        if (RESULT !== e.res) begin n_mis++; $display("FAIL fair_result: got %h expected %h", RESULT, e.res); end
        if (prev >= 0) begin
          n_cmp++;
          if (at - prev != adder_lat + 4) begin n_mis++; $display("FAIL fair_spacing: got %0d expected %0d", at - prev, adder_lat + 4); end
        end
        prev = at;
      end
    end
    repeat (8) begin
      @(negedge CLK);
      n_cmp++;
      if (ACK_REQ !== '0) begin n_mis++; $display("FAIL fair_extra_ack: got %b expected 0", ACK_REQ); end
    end
    n_cmp++;
    if (bs_cnt - bs0 != 4) begin n_mis++; $display("FAIL fair_begin_count: got %0d expected 4", bs_cnt - bs0); end
  endtask

  task automatic test_pointer_wrap();
    bit ok; int idx, at;
    exp_t e;
    repeat (2) @(negedge CLK);
    drive_req(3, 32'h0000_0300, 32'h0000_0011, C_OP_SUB);
    drive_req(0, 32'h0000_0100, 32'h0000_0022, C_OP_ADD);
    sb.push_back('{0, fp_ref(32'h0000_0100, 32'h0000_0022, C_OP_ADD)});
    sb.push_back('{3, fp_ref(32'h0000_0300, 32'h0000_0011, C_OP_SUB)});
    for (int j = 0; j < 2; j++) begin
      wait_ack(ok, idx, at);
      n_cmp++;
      if (!ok || sb.size() == 0) begin
        n_mis++; $display("FAIL wrap_ack_timeout: got no ack expected ack %0d", j);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (idx != e.idx || RESULT !== e.res) begin
          n_mis++; $display("FAIL wrap_grant: got %0d/%h expected %0d/%h", idx, RESULT, e.idx, e.res);
        end
      end
    end
  endtask

  task automatic test_single_add();
    bit ok; int idx, at, c0;
    exp_t e;
    repeat (2) @(negedge CLK);
    c0 = cyc;
    drive_req(0, 32'h3F800000, 32'h40000000, C_OP_ADD);
    sb.push_back('{0, 32'h40400000});
    wait_ack(ok, idx, at);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL add_ack_timeout: got no ack expected ack");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (bs_cyc != c0 + 2) begin n_mis++; $display("FAIL add_begin_cycle: got %0d expected %0d", bs_cyc - c0, 2); end
      n_cmp++;
      if (at != c0 + 8) begin n_mis++; $display("FAIL add_ack_cycle: got %0d expected %0d", at - c0, 8); end
      n_cmp++;
      if (ACK_REQ !== 4'b0001) begin n_mis++; $display("FAIL add_ack_vec: got %b expected 0001", ACK_REQ); end
      n_cmp++;
      if (RESULT !== e.res) begin n_mis++; $display("FAIL add_result: got %h expected %h", RESULT, e.res); end
    end
  endtask

  task automatic test_subtract();
    bit started, done, stab_bad;
    logic [NREQ-1:0] ack_seen;
    exp_t e;
    started = 1'b0; done = 1'b0; stab_bad = 1'b0; ack_seen = '0;
    repeat (2) @(negedge CLK);
    drive_req(2, 32'h40400000, 32'h3F800000, C_OP_SUB);
    sb.push_back('{2, 32'h40000000});
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge CLK);
      if (Begin_SUM === 1'b1) started = 1'b1;
      if (started && (ADD_SUBT !== 1'b1 || OP_A !== 32'h40400000 || OP_B !== 32'h3F800000)) stab_bad = 1'b1;
      if (ACK_REQ !== '0) begin done = 1'b1; ack_seen = ACK_REQ; REQ[2] = 1'b0; end
    end
    n_cmp++;
    if (!done) begin
      n_mis++; $display("FAIL sub_ack_timeout: got no ack expected ack");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (ack_seen !== 4'b0100) begin n_mis++; $display("FAIL sub_ack_vec: got %b expected 0100", ack_seen); end
      n_cmp++;
      if (RESULT !== e.res) begin n_mis++; $display("FAIL sub_result: got %h expected %h", RESULT, e.res); end
      n_cmp++;
      if (stab_bad) begin n_mis++; $display("FAIL sub_operand_stable: got unstable expected stable"); end
    end
  endtask

  task automatic test_timeout();
    bit ok; int idx, at;
    exp_t e;
    adder_hang = 1'b1;
    repeat (2) @(negedge CLK);
    drive_req(3, 32'h1234_5678, 32'h0000_0001, C_OP_ADD);
    sb.push_back('{3, 32'h0});
    wait_ack(ok, idx, at);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL to_ack_timeout: got no ack expected ack");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (at - (bs_cyc + 1) != TIMEOUT) begin n_mis++; $display("FAIL to_ack_cycle: got %0d expected %0d", at - (bs_cyc + 1), TIMEOUT); end
      n_cmp++;
      if (idx != e.idx || RESULT !== e.res) begin n_mis++; $display("FAIL to_result: got %0d/%h expected %0d/%h", idx, RESULT, e.idx, e.res); end
      n_cmp++;
      if (ERR_TIMEOUT !== 1'b1) begin n_mis++; $display("FAIL to_err_set: got %b expected 1", ERR_TIMEOUT); end
    end
    repeat (5) @(negedge CLK);
    n_cmp++;
    if (ERR_TIMEOUT !== 1'b1 || BUSY !== 1'b0) begin n_mis++; $display("FAIL to_err_sticky: got %b/%b expected 1/0", ERR_TIMEOUT, BUSY); end
    adder_hang = 1'b0;
  endtask

  task automatic test_timeout_ack_edge();
    bit ok; int idx, at, c0;
    exp_t e;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if (ERR_TIMEOUT !== 1'b0) begin n_mis++; $display("FAIL edge_err_clear: got %b expected 0", ERR_TIMEOUT); end
    @(negedge CLK);
    RST_N = 1'b1;
    adder_lat = TIMEOUT;
    repeat (2) @(negedge CLK);
    c0 = cyc;
    drive_req(1, 32'h0000_5000, 32'h0000_0123, C_OP_SUB);
    sb.push_back('{1, fp_ref(32'h0000_5000, 32'h0000_0123, C_OP_SUB)});
    wait_ack(ok, idx, at);
    n_cmp++;
    if (!ok) begin
      n_mis++; $display("FAIL edge_ack_timeout: got no ack expected ack");
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (at != c0 + 3 + TIMEOUT) begin n_mis++; $display("FAIL edge_ack_cycle: got %0d expected %0d", at - c0, 3 + TIMEOUT); end
      n_cmp++;
      if (idx != e.idx || RESULT !== e.res) begin n_mis++; $display("FAIL edge_result: got %0d/%h expected %0d/%h", idx, RESULT, e.idx, e.res); end
      n_cmp++;
      if (ERR_TIMEOUT !== 1'b0) begin n_mis++; $display("FAIL edge_no_err: got %b expected 0", ERR_TIMEOUT); end
    end
    adder_lat = 5;
  endtask

  task automatic test_reset_mid_wait();
    bit ok, seen; int idx, at, acks;
    exp_t e;
    adder_hang = 1'b1; seen = 1'b0; acks = 0;
    repeat (2) @(negedge CLK);
    drive_req(3, 32'h0000_0777, 32'h0000_0042, C_OP_SUB);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (Begin_SUM === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_mis++; $display("FAIL rst_begin_timeout: got no Begin_SUM expected pulse"); end
    repeat (3) @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({ACK_REQ, RESULT, BUSY, ERR_TIMEOUT, Begin_SUM, ADD_SUBT, OP_A, OP_B} !== '0) begin
      n_mis++; $display("FAIL rst_async_outputs: got %h expected 0", {ACK_REQ, RESULT, BUSY, ERR_TIMEOUT, Begin_SUM, ADD_SUBT, OP_A, OP_B});
    end
    REQ = '0;
    @(negedge CLK);
    RST_N = 1'b1;
    adder_hang = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (ACK_REQ !== '0) acks++;
    end
    n_cmp++;
    if (acks != 0 || BUSY !== 1'b0) begin n_mis++; $display("FAIL rst_no_ack: got %0d acks busy %b expected 0/0", acks, BUSY); end
    drive_req(3, 32'h0000_0900, 32'h0000_0009, C_OP_ADD);
    drive_req(1, 32'h0000_0A00, 32'h0000_000A, C_OP_SUB);
    sb.push_back('{1, fp_ref(32'h0000_0A00, 32'h0000_000A, C_OP_SUB)});
    sb.push_back('{3, fp_ref(32'h0000_0900, 32'h0000_0009, C_OP_ADD)});
    for (int j = 0; j < 2; j++) begin
      wait_ack(ok, idx, at);
      n_cmp++;
      if (!ok || sb.size() == 0) begin
        n_mis++; $display("FAIL rst_after_ack_timeout: got no ack expected ack %0d", j);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (idx != e.idx || RESULT !== e.res) begin
          n_mis++; $display("FAIL rst_after_grant: got %0d/%h expected %0d/%h", idx, RESULT, e.idx, e.res);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_pointer_wrap();
    test_single_add();
    test_subtract();
    test_timeout();
    test_timeout_ack_edge();
    test_reset_mid_wait();
    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
